silife_max7219_rx: RTL and testbench



---
 rtl/silife_max7219_rx_if.sv | 9 +
 rtl/silife_max7219_rx.sv | 165 ++++++++++++++++
 tb/tb_silife_max7219_rx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/silife_max7219_rx_if.sv
// rtl/silife_max7219_rx_if.sv - 3-wire MAX7219 serial link (CS, SCK, MOSI)
interface silife_max7219_rx_if;
    logic cs;
    logic sck;
    logic mosi;

    modport master (output cs, output sck, output mosi);
    modport slave  (input  cs, input  sck, input  mosi);
endinterface

// File: rtl/silife_max7219_rx.sv
// rtl/silife_max7219_rx.sv - oversampling MAX7219 serial receiver rebuilding the display register file
module silife_max7219_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    silife_max7219_rx_if.slave   spi,
    input  logic [2:0]           i_row_select,
    output logic [7:0]           o_row,
    output logic [7:0]           o_decode_mode,
    output logic [3:0]           o_intensity,
    output logic [2:0]           o_scan_limit,
    output logic                 o_shutdown,
    output logic                 o_display_test,
    output logic                 o_frame_valid,
    output logic [3:0]           o_frame_addr,
    output logic [7:0]           o_frame_data,
    output logic                 o_frame_error
);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   sck_d;
    logic                   cs_s;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sck_rise;

    state_t                 state;
    state_t                 state_next;
    logic                   clear;
    logic                   shift_en;
    logic                   commit;
    logic                   short_frame;

    logic [15:0]            shift_reg;
    logic [4:0]             bit_cnt;
    logic [7:0]             digit [0:7];

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = ~sck_d & sck_s;

    // Idle values chosen so that a quiet bus produces no spurious edges after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sck_d     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            cs_d      <= cs_s;
            sck_d     <= sck_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        clear       = 1'b0;
        shift_en    = 1'b0;
        commit      = 1'b0;
        short_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    clear      = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // An SCK edge coinciding with the CS rise is dropped: cs_s is already high.
                if (cs_rise) begin
                    state_next = ST_IDLE;
                    if (bit_cnt >= 5'd16) begin
                        commit = 1'b1;
                    end else if (bit_cnt != 5'd0) begin
                        short_frame = 1'b1;
                    end
                end else if (sck_rise && !cs_s) begin
                    shift_en = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[14:0], mosi_s};
            if (bit_cnt != 5'd31) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    // Only the last 16 bits count, so longer daisy-chained streams pass through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                digit[i] <= '0;
            end
            o_decode_mode  <= '0;
            o_intensity    <= '0;
            o_scan_limit   <= '0;
            o_shutdown     <= 1'b1;
            o_display_test <= 1'b0;
            o_frame_valid  <= 1'b0;
            o_frame_addr   <= '0;
            o_frame_data   <= '0;
            o_frame_error  <= 1'b0;
        end else begin
            o_frame_valid <= commit;
            if (short_frame) begin
                o_frame_error <= 1'b1;
            end
            if (commit) begin
                o_frame_addr <= shift_reg[11:8];
                o_frame_data <= shift_reg[7:0];
                case (shift_reg[11:8])
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digit[shift_reg[10:8] - 3'd1] <= shift_reg[7:0];
                    4'h9: o_decode_mode  <= shift_reg[7:0];
                    4'hA: o_intensity    <= shift_reg[3:0];
                    4'hB: o_scan_limit   <= shift_reg[2:0];
                    4'hC: o_shutdown     <= ~shift_reg[0];
                    4'hF: o_display_test <= shift_reg[0];
                    default: ;
                endcase
            end
        end
    end

    assign o_row = digit[i_row_select];

endmodule

// File: tb/tb_silife_max7219_rx.sv
// tb/tb_silife_max7219_rx.sv - scoreboard bench for silife_max7219_rx with random and directed frames
module tb_silife_max7219_rx;
    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] i_row_select = 3'd0;
    logic [7:0] o_row;
    logic [7:0] o_decode_mode;
    logic [3:0] o_intensity;
    logic [2:0] o_scan_limit;
    logic       o_shutdown;
    logic       o_display_test;
    logic       o_frame_valid;
    logic [3:0] o_frame_addr;
    logic [7:0] o_frame_data;
    logic       o_frame_error;

    silife_max7219_rx_if spi ();

    silife_max7219_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk            (clk),
        .reset          (reset),
        .spi            (spi),
        .i_row_select   (i_row_select),
        .o_row          (o_row),
        .o_decode_mode  (o_decode_mode),
        .o_intensity    (o_intensity),
        .o_scan_limit   (o_scan_limit),
        .o_shutdown     (o_shutdown),
        .o_display_test (o_display_test),
        .o_frame_valid  (o_frame_valid),
        .o_frame_addr   (o_frame_addr),
        .o_frame_data   (o_frame_data),
        .o_frame_error  (o_frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         rise_cyc;
    } exp_t;
    exp_t exp_q[$];

    // Reference register file
    logic [7:0] m_digit [0:7];
    logic [7:0] m_decode;
    logic [3:0] m_intensity;
    logic [2:0] m_scan;
    logic       m_shutdown;
    logic       m_test;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    logic       m_error;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_decode = 0; m_intensity = 0; m_scan = 0;
        m_shutdown = 1; m_test = 0; m_addr = 0; m_data = 0; m_error = 0;
    endtask

    task automatic model_apply(input logic [15:0] f);
        int a;
        a = int'(f[11:8]);
        m_addr = f[11:8];
        m_data = f[7:0];
        if (a >= 1 && a <= 8) m_digit[a-1] = f[7:0];
        else if (a == 9)  m_decode = f[7:0];
        else if (a == 10) m_intensity = f[3:0];
        else if (a == 11) m_scan = f[2:0];
        else if (a == 12) m_shutdown = !f[0];
        else if (a == 15) m_test = f[0];
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: each pulse must match the oldest expected frame and its latency.
    always @(negedge clk) begin
        if (!reset && o_frame_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_addr", 32'(o_frame_addr), 32'(e.addr));
                chk("frame_data", 32'(o_frame_data), 32'(e.data));
                chk("pulse_latency", 32'(cyc - e.rise_cyc), 32'(SYNC_STAGES + 1));
            end
        end
    end

    task automatic check_all(input string tag);
        chk({tag, "_decode"},    32'(o_decode_mode),  32'(m_decode));
        chk({tag, "_intensity"}, 32'(o_intensity),    32'(m_intensity));
        chk({tag, "_scan"},      32'(o_scan_limit),   32'(m_scan));
        chk({tag, "_shutdown"},  32'(o_shutdown),     32'(m_shutdown));
        chk({tag, "_test"},      32'(o_display_test), 32'(m_test));
        chk({tag, "_last_addr"}, 32'(o_frame_addr),   32'(m_addr));
        chk({tag, "_last_data"}, 32'(o_frame_data),   32'(m_data));
        chk({tag, "_error"},     32'(o_frame_error),  32'(m_error));
        chk({tag, "_valid_idle"}, 32'(o_frame_valid), 32'd0);
        for (int r = 0; r < 8; r++) begin
            i_row_select = 3'(r);
            #1;
            chk($sformatf("%s_row%0d", tag, r), 32'(o_row), 32'(m_digit[r]));
        end
    endtask

    // Sends the low nbits of val MSB first at SCK = clk/8, then updates the model.
    task automatic send_frame(input logic [31:0] val, input int nbits);
        spi.cs = 1'b0;
        clks(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi.mosi = val[i];
            clks(4);
            spi.sck = 1'b1;
            clks(4);
            spi.sck = 1'b0;
        end
        clks(4);
        spi.cs = 1'b1;
        if (nbits >= 16) begin
            exp_t e;
            e.addr = val[11:8];
            e.data = val[7:0];
            e.rise_cyc = cyc;
            exp_q.push_back(e);
            model_apply(val[15:0]);
        end else if (nbits > 0) begin
            m_error = 1'b1;
        end
        clks(8);
        chk("pending_pulses", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        spi.cs = 1'b1;
        spi.sck = 1'b0;
        spi.mosi = 1'b0;
        model_reset();
        clks(3);
        reset = 1'b0;
        clks(2);
        check_all("reset");

        send_frame(32'h0A05, 16);
        check_all("intensity");

        for (int k = 0; k < 8; k++) begin
            logic [7:0] pat;
            pat = 8'h81 >> k | 8'h81 << k;
            send_frame({16'h0, 4'h0, 4'(k + 1), pat}, 16);
        end
        check_all("rows");
        send_frame(32'h0C01, 16);
        chk("shutdown_off", 32'(o_shutdown), 32'd0);
        send_frame(32'h0C00, 16);
        chk("shutdown_on", 32'(o_shutdown), 32'd1);

        send_frame(32'hFF0301, 24);
        check_all("daisy24");

        send_frame(32'h2A5, 10);
        check_all("short10");
        send_frame(32'h0F01, 16);
        check_all("test_on");

        send_frame(32'h0, 0);
        check_all("empty_cs");
        send_frame(32'h0000, 16);
        check_all("noop");

        for (int n = 0; n < 24; n++) begin
            logic [31:0] v;
            int nb;
            v = $urandom();
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15))
                                             : int'($urandom_range(16, 24));
            send_frame(v, nb);
            check_all($sformatf("rand%0d", n));
        end

        // Reset while a frame of 0x0B07 is half shifted in
        spi.cs = 1'b0;
        clks(4);
        for (int i = 15; i >= 8; i--) begin
            logic [15:0] f;
            f = 16'h0B07;
            spi.mosi = f[i];
            clks(4);
            spi.sck = 1'b1;
            clks(4);
            spi.sck = 1'b0;
        end
        reset = 1'b1;
        clks(2);
        reset = 1'b0;
        clks(2);
        spi.cs = 1'b1;
        clks(8);
        model_reset();
        chk("reset_mid_pending", 32'(exp_q.size()), 32'd0);
        check_all("reset_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
